// File: rtl/button_op_latch.sv
// Debounced one-operation-per-press front end for the lab ALU: syncs the four pushbuttons,
// latches A/B and a one-hot op on acceptance. Optional op counter under BUTTON_OP_COUNT_EN.
module button_op_latch #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pushbutton_one,
    input  logic       pushbutton_two,
    input  logic       pushbutton_three,
    input  logic       pushbutton_four,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] op_sel,
    output logic [3:0] A_q,
    output logic [3:0] B_q,
    output logic       op_valid,
    output logic       busy
`ifdef BUTTON_OP_COUNT_EN
    ,
    output logic [7:0] op_count
`endif
);

    localparam int unsigned BTN_W = 4;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_HOLD     = 2'd2;
    localparam logic [1:0] S_RELEASE  = 2'd3;

    logic [BTN_W-1:0] btn_raw;
    logic [BTN_W-1:0] btn_meta;
    logic [BTN_W-1:0] btn_s;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BTN_W-1:0] cand_q, cand_d;
    logic             accept_c;
    logic             one_hot_c;
    logic             last_c;

    assign btn_raw = {pushbutton_four, pushbutton_three, pushbutton_two, pushbutton_one};

    // Two-flop synchronizer per button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= '0;
            btn_s    <= '0;
        end else begin
            btn_meta <= btn_raw;
            btn_s    <= btn_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

    assign one_hot_c = (btn_s != '0) && ((btn_s & (btn_s - BTN_W'(1))) == '0);
    // The sample that makes the run DEBOUNCE_CYCLES long is the one seen while cnt is one short
    assign last_c    = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        accept_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (one_hot_c) begin
                    state_d = S_DEBOUNCE;
                    cand_d  = btn_s;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_DEBOUNCE: begin
                if (btn_s != cand_q) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (last_c) begin
                    state_d  = S_HOLD;
                    cnt_d    = '0;
                    accept_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                cnt_d = '0;
                if (btn_s == '0) begin
                    state_d = S_RELEASE;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_RELEASE: begin
                if (btn_s != '0) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else if (last_c) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Sticky operation/operand registers feeding the ALU
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_sel   <= '0;
            A_q      <= '0;
            B_q      <= '0;
            op_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            op_valid <= accept_c;
            busy     <= (state_d != S_IDLE);
            if (accept_c) begin
                op_sel <= cand_q;
                A_q    <= A;
                B_q    <= B;
            end
        end
    end

`ifdef BUTTON_OP_COUNT_EN
    // Saturating count of accepted operations
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (accept_c && (op_count != 8'hFF)) begin
            op_count <= op_count + 8'd1;
        end
    end
`endif

endmodule
